// File: rtl/serial_parity_checker_pkg.sv
// serial_parity_checker_pkg: shared FSM encodings and default frame width
package serial_parity_checker_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam int DEFAULT_DATA_BITS = 8;
endpackage

// File: rtl/serial_parity_checker_accum.sv
// parity_accum: running XOR parity flop with sync clear and enable
module parity_accum (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);
  logic n1, n2, n3, x;
  // four-NAND XOR gate cell
  assign n1 = ~(q & d);
  assign n2 = ~(q & n1);
  assign n3 = ~(d & n1);
  assign x = ~(n2 & n3);
  always_ff @(posedge clk)
    if (clr) q <= 1'b0;
    else if (en) q <= x;
endmodule

// File: rtl/serial_parity_checker.sv
// serial_parity_checker: deserialises an LSB-first frame and checks its trailing parity bit
module serial_parity_checker
  import serial_parity_checker_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter logic ODD_PARITY = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 busy,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_calc,
  output logic                 parity_err,
  output logic                 frame_done
);
  localparam int CW = $clog2(DATA_BITS) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);
  logic [1:0] state, state_nx;
  logic [CW-1:0] cnt;
  logic [DATA_BITS-1:0] sreg;
  logic acc, take_data, take_par;
  assign take_data = !start && state == ST_DATA && bit_valid;
  assign take_par = !start && state == ST_PARITY && bit_valid;
  always_comb
    state_nx = start ? ST_DATA :
               state == ST_DATA ? ((bit_valid && cnt == LAST) ? ST_PARITY : ST_DATA) :
               state == ST_PARITY ? (bit_valid ? ST_DONE : ST_PARITY) : ST_IDLE;
  parity_accum u_accum (
    .clk(clk),
    .clr(!rst_n || start),
    .en(take_data),
    .d(bit_in),
    .q(acc)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      sreg <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      data_out <= '0;
      parity_calc <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state <= state_nx;
      busy <= state_nx == ST_DATA || state_nx == ST_PARITY;
      frame_done <= state_nx == ST_DONE;
      if (start) begin
        cnt <= '0;
        sreg <= '0;
      end else if (take_data) begin
        cnt <= cnt + 1'b1;
        sreg <= sreg | (DATA_BITS'(bit_in) << cnt);
      end
      if (take_par) begin
        data_out <= sreg;
        parity_calc <= acc;
        parity_err <= acc ^ bit_in ^ ODD_PARITY;
      end
    end
  end
endmodule
